reg_file_sync: RTL
==================

Name: reg_file_sync

Overview:
- Parametrised successor to the CPU register file: 2 read ports, 1 write port.
- Writes are clocked and reads are registered, so the block is fully synchronous.
- After reset, a sweep engine clears every register, one per cycle; busy is high while it runs.
- Sits between decode (read ports) and writeback (write port) in the datapath.

Parameters:
- DATA_W, 32, width of each register and of the data ports.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- read_addr1  in  ADDR_W  read port 1 address.
- read_enable1  in  1  capture enable, port 1.
- read_addr2  in  ADDR_W  read port 2 address.
- read_enable2  in  1  capture enable, port 2.
- write_addr  in  ADDR_W  write address.
- write_data  in  DATA_W  write data.
- write_enable1  in  1  write strobe.
- read_data1  out  DATA_W  registered read data, port 1.
- read_data2  out  DATA_W  registered read data, port 2.
- busy  out  1  high while the clear sweep runs.
- write_err  out  1  one-cycle pulse: a write was dropped because busy was high.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset (rst=1 at an edge):
  - Enter CLEAR with clr_cnt=0.
  - read_data1=0, read_data2=0, busy=1, write_err=0.
  - Array contents are not touched on the reset edge itself.
- FSM states: CLEAR, READY.
- CLEAR:
  - Each cycle: regfile[clr_cnt] <= 0, then clr_cnt increments.
  - When clr_cnt == DEPTH-1: write that last entry and go to READY on the same edge.
  - Duration is exactly DEPTH cycles after rst deasserts; busy falls on the DEPTH-th edge.
  - rst mid-sweep restarts at clr_cnt=0.
- Writes during CLEAR: write_enable1=1 is ignored, and write_err=1 on the next cycle. This also applies on the final CLEAR cycle.
- Reads during CLEAR: enabled ports load 0 and disabled ports hold. Stale data is never exposed.
- READY, write path:
  - write_enable1=1 gives regfile[write_addr] <= write_data at the edge.
  - The write is visible to a read issued on the following cycle.
- READY, read path:
  - read_enableN=1 gives read_dataN <= regfile[read_addrN] at the edge (latency 1 cycle).
  - read_enableN=0 holds read_dataN.
  - The two ports are independent and may use the same address.
- Same-cycle write and read to the same address: result depends on the optional feature below.
- write_err is 0 in READY.
- clr_cnt is ADDR_W bits wide; there is no wrap beyond DEPTH-1 because the FSM exits.
- There are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - In READY, if write_enable1=1 and read_enableN=1 and read_addrN==write_addr in the same cycle, read_dataN captures write_data (new value).
  - Applies to both ports at once.
- Undefined: read_dataN captures the pre-write array value (old value).
- The array write itself is the same in both builds.

Decomposition:
- Shared package cpu_pkg:
  - rf_state_t enum {RF_CLEAR, RF_READY}.
  - Default constants RF_DATA_W=32 and RF_ADDR_W=4, consumed by the parameters.
- One natural sub-module: rf_clear_seq. It holds the FSM and clr_cnt, and outputs busy, clr_we and clr_addr.
- The top level muxes the write port between the sweep (clr_we/clr_addr with data 0) and the external write port.

Test Plan:
- Reset sweep: assert rst 1 cycle.
  - busy=1 for exactly 16 cycles, then 0.
  - Reads of addr 0..15 afterwards return 32'h0.
- Write/read: write 32'hDEADBEEF to addr 3, then read port1 addr 3 and port2 addr 3 next cycle.
  - Both read_data = 32'hDEADBEEF one cycle after the read cycle.
- Hold: read addr 5 (holding 32'h5) with enable=1, then change addr to 6 with enable=0.
  - read_data1 stays 32'h5.
- Write during CLEAR: write_enable1=1, addr 2, data 32'hFF on the 3rd sweep cycle.
  - write_err pulses 1 cycle.
  - addr 2 reads 0 after READY.
- Same-cycle conflict: addr 7 holds 32'h11; write 32'h22 to addr 7 while reading addr 7 on port 1.
  - Gives 32'h22 with REGFILE_BYPASS_EN defined, 32'h11 without.
  - Next-cycle read gives 32'h22 in both builds.
- Reset mid-sweep: rst at sweep cycle 9.
  - busy stays 1 for a further 16 cycles.
  - read_data1/2 are 0 on the cycle after rst.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file types and default sizes
package cpu_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  function automatic int rf_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// rtl/rf_clear_seq.sv - post-reset sweep that zeroes every register, one per cycle
module rf_clear_seq
  import cpu_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  rf_state_t         state;
  logic [ADDR_W-1:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RF_CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        RF_CLEAR: begin
          // Last entry is written on the same edge that leaves CLEAR, so the counter never wraps.
          if (clr_cnt == LAST_ADDR) begin
            state <= RF_READY;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        RF_READY: begin
          state <= RF_READY;
          busy  <= 1'b0;
        end
        default: begin
          state <= RF_CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we   = (state == RF_CLEAR);
  assign clr_addr = clr_cnt;

endmodule

// File: rtl/reg_file_sync.sv
// rtl/reg_file_sync.sv - 2R/1W synchronous register file with post-reset clear; REGFILE_BYPASS_EN forwards same-cycle writes to reads
module reg_file_sync
  import cpu_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic              read_enable1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic              read_enable2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write_enable1,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              busy,
  output logic              write_err
);

  localparam int DEPTH = rf_depth(ADDR_W);

  logic [DATA_W-1:0] regfile [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_data;
  logic              fwd1;
  logic              fwd2;
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;

  rf_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // The sweep owns the write port while it runs; external writes are dropped.
  always_comb begin
    arr_we   = 1'b0;
    arr_addr = '0;
    arr_data = '0;
    if (clr_we) begin
      arr_we   = 1'b1;
      arr_addr = clr_addr;
      arr_data = '0;
    end else begin
      arr_we   = write_enable1;
      arr_addr = write_addr;
      arr_data = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && arr_we) begin
      regfile[arr_addr] <= arr_data;
    end
  end

  always_comb begin
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`ifdef REGFILE_BYPASS_EN
    fwd1 = write_enable1 && (read_addr1 == write_addr);
    fwd2 = write_enable1 && (read_addr2 == write_addr);
`endif
    rd1_next = fwd1 ? write_data : regfile[read_addr1];
    rd2_next = fwd2 ? write_data : regfile[read_addr2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_data1 <= '0;
      read_data2 <= '0;
      write_err  <= 1'b0;
    end else begin
      write_err <= clr_we & write_enable1;
      // Enabled reads during the sweep return zero so stale contents never leak out.
      if (read_enable1) begin
        read_data1 <= clr_we ? '0 : rd1_next;
      end
      if (read_enable2) begin
        read_data2 <= clr_we ? '0 : rd2_next;
      end
    end
  end

endmodule
